rm_list_sequencer: RTL and testbench

- Sequences the datapath for LDM/STM block transfers.
- Latches the 16-bit register list, base address and P/U bits from the instruction register.
- Each transfer step, presents the next register index and memory address, lowest register first.
- Drives RM_CNTR_DONE to the microsequencer and supplies the base-writeback value.

---
 rtl/rm_seq_pkg.sv | 23 ++
 rtl/rm_lsb_encoder.sv | 23 ++
 rtl/rm_list_sequencer.sv | 144 ++++++++++++++
 tb/tb_rm_list_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rm_seq_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
//   state_e    : sequencer FSM states
//   mode_e     : {P,U} addressing mode encodings (IA/IB/DA/DB)
//   WORD_BYTES : default address increment per transferred register
package rm_seq_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StActive = 2'b01,
        StDone   = 2'b10
    } state_e;

    // Encoded as {P, U}.
    typedef enum logic [1:0] {
        ModeDa = 2'b00,
        ModeIa = 2'b01,
        ModeDb = 2'b10,
        ModeIb = 2'b11
    } mode_e;

endpackage

// File: rtl/rm_lsb_encoder.sv
// Lowest-set-bit encoder for a 16-bit register list.
//   i_vec   : register list
//   o_idx   : index of the lowest set bit (0 when i_vec is zero)
//   o_valid : high when any bit of i_vec is set
module rm_lsb_encoder (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rm_list_sequencer.sv
// Register-list sequencer for LDM/STM block transfers. Latches the register
// list, base address and P/U bits on start, then presents one register index
// and memory address per transfer step, lowest register at lowest address.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_start          : latch operands and begin (or restart) a transfer
//   i_reg_list       : IR[15:0] register list
//   i_pre, i_up      : IR P and U bits
//   i_base_addr      : Rn value
//   i_step           : current transfer completed, advance
//   o_rm_reg         : register index of current transfer
//   o_rm_addr        : memory address of current transfer
//   o_rm_count       : number of registers in the latched list
//   o_busy           : transfer in progress
//   o_rm_cntr_done   : all transfers complete (held until next start)
//   o_wb_addr        : Rn writeback value
module rm_list_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = rm_seq_pkg::WORD_BYTES
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [15:0]       i_reg_list,
    input  logic              i_pre,
    input  logic              i_up,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_step,
    output logic [3:0]        o_rm_reg,
    output logic [ADDR_W-1:0] o_rm_addr,
    output logic [4:0]        o_rm_count,
    output logic              o_busy,
    output logic              o_rm_cntr_done,
    output logic [ADDR_W-1:0] o_wb_addr
);

    import rm_seq_pkg::*;

    state_e            r_state;
    logic [15:0]       r_remaining;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_last_reg;
    logic [4:0]        r_count;
    logic [ADDR_W-1:0] r_wb_addr;
    logic              r_busy;
    logic              r_done;

    logic [3:0]        w_lsb_idx;
    logic              w_lsb_valid;
    logic [4:0]        w_count;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_word;
    logic [ADDR_W-1:0] w_start_addr;
    logic [ADDR_W-1:0] w_wb_addr;
    logic [15:0]       w_rem_next;
    mode_e             w_mode;

    rm_lsb_encoder u_lsb_encoder (
        .i_vec   (r_remaining),
        .o_idx   (w_lsb_idx),
        .o_valid (w_lsb_valid)
    );

    always_comb begin
        w_count = '0;
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + 5'(i_reg_list[i]);
        end
    end

    assign w_word     = ADDR_W'(WORD_BYTES);
    assign w_span     = ADDR_W'(w_count) * w_word;
    assign w_wb_addr  = i_up ? (i_base_addr + w_span) : (i_base_addr - w_span);
    assign w_mode     = mode_e'({i_pre, i_up});
    // Clears the lowest set bit.
    assign w_rem_next = r_remaining & (r_remaining - 16'd1);

    // Descending modes start at the bottom of the block so that transfers
    // always run upward in address.
    always_comb begin
        w_start_addr = i_base_addr;
        unique case (w_mode)
            ModeIa:  w_start_addr = i_base_addr;
            ModeIb:  w_start_addr = i_base_addr + w_word;
            ModeDa:  w_start_addr = i_base_addr - w_span + w_word;
            ModeDb:  w_start_addr = i_base_addr - w_span;
            default: w_start_addr = i_base_addr;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_addr      <= '0;
            r_last_reg  <= '0;
            r_count     <= '0;
            r_wb_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_start) begin
            // Restart wins over step and aborts any transfer in flight.
            r_remaining <= i_reg_list;
            r_count     <= w_count;
            r_wb_addr   <= w_wb_addr;
            r_addr      <= w_start_addr;
            r_last_reg  <= '0;
            if (i_reg_list != 16'd0) begin
                r_state <= StActive;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end else begin
                r_state <= StDone;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end else begin
            case (r_state)
                StActive: begin
                    if (i_step) begin
                        r_remaining <= w_rem_next;
                        r_addr      <= r_addr + w_word;
                        r_last_reg  <= w_lsb_idx;
                        if (w_rem_next == 16'd0) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // While active, the index follows the remaining list; otherwise it holds
    // the last transferred register.
    assign o_rm_reg       = (r_state == StActive && w_lsb_valid) ? w_lsb_idx : r_last_reg;
    assign o_rm_addr      = r_addr;
    assign o_rm_count     = r_count;
    assign o_busy         = r_busy;
    assign o_rm_cntr_done = r_done;
    assign o_wb_addr      = r_wb_addr;

endmodule

// File: tb/tb_rm_list_sequencer.sv
// Directed self-checking bench for rm_list_sequencer with a scoreboard queue
// of expected (register, address) pairs.
module tb_rm_list_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] reg_list;
    logic        pre;
    logic        up;
    logic [31:0] base_addr;
    logic        step;
    logic [3:0]  rm_reg;
    logic [31:0] rm_addr;
    logic [4:0]  rm_count;
    logic        busy;
    logic        rm_cntr_done;
    logic [31:0] wb_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  exp_count;
    logic [31:0] exp_wb;

    rm_list_sequencer #(
        .ADDR_W     (32),
        .WORD_BYTES (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_reg_list     (reg_list),
        .i_pre          (pre),
        .i_up           (up),
        .i_base_addr    (base_addr),
        .i_step         (step),
        .o_rm_reg       (rm_reg),
        .o_rm_addr      (rm_addr),
        .o_rm_count     (rm_count),
        .o_busy         (busy),
        .o_rm_cntr_done (rm_cntr_done),
        .o_wb_addr      (wb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: expected transfers, count and writeback derived from the start operands.
    task automatic model_start(input logic [15:0] l, input logic p, input logic u,
                               input logic [31:0] b);
        int          n;
        logic [31:0] a;
        exp_t        e;
        n = 0;
        for (int i = 0; i < 16; i++) if (l[i]) n++;
        if (u) a = p ? b + 32'd4 : b;
        else   a = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            if (l[i]) begin
                e.r = 4'(i);
                e.a = a;
                sb.push_back(e);
                a = a + 32'd4;
            end
        end
        exp_count = 5'(n);
        exp_wb    = u ? b + 32'(4 * n) : b - 32'(4 * n);
    endtask

    task automatic do_start(input logic [15:0] l, input logic p, input logic u,
                            input logic [31:0] b, input logic with_step);
        model_start(l, p, u, b);
        start     = 1'b1;
        reg_list  = l;
        pre       = p;
        up        = u;
        base_addr = b;
        step      = with_step;
        tick();
        start = 1'b0;
        step  = 1'b0;
        chk("count", 64'(rm_count), 64'(exp_count));
        chk("wb_addr", 64'(wb_addr), 64'(exp_wb));
    endtask

    // Consume n scoreboard entries, holding each for gap extra cycles.
    task automatic run_steps(input int n, input int gap);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 64'(1), 64'(0));
                return;
            end
            e = sb.pop_front();
            for (int g = 0; g <= gap; g++) begin
                chk("busy", 64'(busy), 64'(1));
                chk("done_low", 64'(rm_cntr_done), 64'(0));
                chk("rm_reg", 64'(rm_reg), 64'(e.r));
                chk("rm_addr", 64'(rm_addr), 64'(e.a));
                if (g < gap) tick();
            end
            step = 1'b1;
            tick();
            step = 1'b0;
        end
    endtask

    task automatic check_done_held();
        chk("done", 64'(rm_cntr_done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("done_held", 64'(rm_cntr_done), 64'(1));
        chk("done_held_busy", 64'(busy), 64'(0));
        chk("done_held_wb", 64'(wb_addr), 64'(exp_wb));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        reg_list  = '0;
        pre       = 1'b0;
        up        = 1'b0;
        base_addr = '0;
        step      = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(rm_cntr_done), 64'(0));
        chk("rst_count", 64'(rm_count), 64'(0));
        chk("rst_reg", 64'(rm_reg), 64'(0));
        chk("rst_addr", 64'(rm_addr), 64'(0));
        chk("rst_wb", 64'(wb_addr), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Step while idle does nothing.
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("idle_step_busy", 64'(busy), 64'(0));
        chk("idle_step_done", 64'(rm_cntr_done), 64'(0));

        // IA
        do_start(16'h00F0, 1'b0, 1'b1, 32'h0000_1000, 1'b0);
        run_steps(4, 0);
        check_done_held();

        // DB
        do_start(16'h8001, 1'b1, 1'b0, 32'h0000_2000, 1'b0);
        run_steps(2, 0);
        check_done_held();

        // IB with address wrap
        do_start(16'h0003, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_steps(2, 0);
        check_done_held();

        // DA
        do_start(16'h0C00, 1'b0, 1'b0, 32'h0000_6000, 1'b0);
        run_steps(2, 0);
        check_done_held();

        // Empty list
        do_start(16'h0000, 1'b0, 1'b1, 32'h0000_7000, 1'b0);
        chk("empty_wb_base", 64'(wb_addr), 64'h7000);
        check_done_held();

        // Stall: gaps of 3 cycles between steps
        do_start(16'h0101, 1'b0, 1'b1, 32'h0000_5000, 1'b0);
        run_steps(2, 3);
        check_done_held();

        // Restart with simultaneous step aborts the in-flight transfer
        do_start(16'h00FF, 1'b0, 1'b1, 32'h0000_1000, 1'b0);
        run_steps(2, 0);
        do_start(16'h0010, 1'b0, 1'b1, 32'h0000_3000, 1'b1);
        run_steps(1, 0);
        check_done_held();

        // Async reset mid-transfer, between clock edges
        do_start(16'h0101, 1'b0, 1'b1, 32'h0000_4000, 1'b0);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(rm_cntr_done), 64'(0));
        chk("arst_count", 64'(rm_count), 64'(0));
        chk("arst_reg", 64'(rm_reg), 64'(0));
        chk("arst_addr", 64'(rm_addr), 64'(0));
        chk("arst_wb", 64'(wb_addr), 64'(0));
        sb.delete();
        tick();
        rst_n = 1'b1;
        step  = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_done", 64'(rm_cntr_done), 64'(0));
        chk("post_rst_addr", 64'(rm_addr), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
